// File: rtl/truth_table_sweeper.sv
// Sweeps an N_IN-input combinational block through every input vector, captures
// its truth table after a settle dwell, and compares it against an expected table.
module truth_table_sweeper #(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned DWELL = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [(1<<N_IN)-1:0]  expected,
   output logic [N_IN-1:0]       dut_in,
   input  logic                  dut_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [(1<<N_IN)-1:0]  captured,
   output logic [N_IN:0]         mismatch_cnt
);

   localparam int unsigned NV = 1 << N_IN;
   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t          state, state_nx;
   logic [N_IN-1:0] idx;
   logic [CW-1:0]   dwell_cnt;
   logic [NV-1:0]   exp_q;
   logic            last_vec;
   logic            dwell_end;
   logic            miss;
   logic [N_IN:0]   cnt_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      last_vec  = (idx == '1);
      dwell_end = (dwell_cnt == CW'(DWELL - 1));
      miss      = dut_out ^ exp_q[idx];
      cnt_nx    = mismatch_cnt + {{N_IN{1'b0}}, miss};
      state_nx  = state;
      busy      = 1'b0;
      done      = 1'b0;
      dut_in    = '0;
      case (state)
         IDLE: begin
            if (start && !abort) state_nx = SETTLE;
         end
         SETTLE: begin
            busy   = 1'b1;
            dut_in = idx;
            if (abort)          state_nx = IDLE;
            else if (dwell_end) state_nx = SAMPLE;
         end
         SAMPLE: begin
            busy   = 1'b1;
            dut_in = idx;
            if (abort)         state_nx = IDLE;
            else if (last_vec) state_nx = DONE;
            else               state_nx = SETTLE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // pass is resolved from the final count on the edge entering DONE so it is
   // already valid while done is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx          <= '0;
         dwell_cnt    <= '0;
         exp_q        <= '0;
         captured     <= '0;
         mismatch_cnt <= '0;
         pass         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  exp_q        <= expected;
                  captured     <= '0;
                  mismatch_cnt <= '0;
                  pass         <= 1'b0;
                  idx          <= '0;
                  dwell_cnt    <= '0;
               end
            end
            SETTLE: begin
               if (abort) pass <= 1'b0;
               else       dwell_cnt <= dwell_cnt + 1'b1;
            end
            SAMPLE: begin
               if (abort) begin
                  pass <= 1'b0;
               end else begin
                  captured[idx] <= dut_out;
                  mismatch_cnt  <= cnt_nx;
                  if (last_vec) begin
                     pass <= (cnt_nx == '0);
                  end else begin
                     idx       <= idx + 1'b1;
                     dwell_cnt <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
